// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter that shares one uart_tx serializer between NUM_REQ byte streams.
// A grant lasts for one packet, capped by MAX_BURST bytes and an idle-hold timeout.
module uart_tx_scheduler #(
   parameter int NUM_REQ      = 4,
   parameter int DATA_WIDTH   = 8,
   parameter int MAX_BURST    = 16,
   parameter int HOLD_TIMEOUT = 64,
   localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
   localparam int BW  = $clog2(MAX_BURST + 1),
   localparam int HW  = (HOLD_TIMEOUT > 1) ? $clog2(HOLD_TIMEOUT) : 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   input  logic [NUM_REQ-1:0]            req_last,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic                          tx_start,
   output logic [DATA_WIDTH-1:0]         tx_data,
   input  logic                          tx_busy,
   input  logic                          tx_done,
   output logic                          grant_active,
   output logic [IDW-1:0]                grant_id,
   output logic [1:0]                    state_dbg
);

   // Handshake: a byte moves from requester i when req_valid[i] & req_ready[i] at a rising
   // edge. Valid never waits on ready; ready is only offered to the grantee while !tx_busy.

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SEND = 2'd1,
      S_WAIT = 2'd2
   } state_t;

   state_t                state, state_n;
   logic [IDW-1:0]        rr_ptr, rr_n;
   logic [IDW-1:0]        gid_n;
   logic [BW-1:0]         burst_cnt, burst_n;
   logic [HW-1:0]         hold_cnt, hold_n;
   logic                  last_q, last_n;
   logic                  start_n;
   logic [DATA_WIDTH-1:0] data_n;
   logic                  rel;

   logic                  found;
   logic [IDW-1:0]        sel;
   logic [IDW-1:0]        cand;

   logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign data_arr[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
   end

   // First valid requester at or above rr_ptr, wrapping modulo NUM_REQ.
   always_comb begin
      found = 1'b0;
      sel   = '0;
      cand  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (int'(rr_ptr) + k >= NUM_REQ) begin
            cand = IDW'(int'(rr_ptr) + k - NUM_REQ);
         end else begin
            cand = IDW'(int'(rr_ptr) + k);
         end
         if (!found && req_valid[cand]) begin
            found = 1'b1;
            sel   = cand;
         end
      end
   end

   always_comb begin
      state_n   = state;
      rr_n      = rr_ptr;
      gid_n     = grant_id;
      burst_n   = burst_cnt;
      hold_n    = hold_cnt;
      last_n    = last_q;
      start_n   = 1'b0;
      data_n    = tx_data;
      req_ready = '0;
      rel       = 1'b0;

      case (state)
         S_IDLE: begin
            if (found) begin
               gid_n   = sel;
               burst_n = '0;
               hold_n  = '0;
               state_n = S_SEND;
            end
         end

         S_SEND: begin
            req_ready[grant_id] = !tx_busy;
            if (req_valid[grant_id] && !tx_busy) begin
               start_n = 1'b1;
               data_n  = data_arr[grant_id];
               last_n  = req_last[grant_id];
               burst_n = burst_cnt + BW'(1);
               hold_n  = '0;
               state_n = S_WAIT;
            end else if (!req_valid[grant_id]) begin
               // Grantee has gone quiet; give the line away once the hold budget is spent.
               if (hold_cnt == HW'(HOLD_TIMEOUT - 1)) begin
                  rel = 1'b1;
               end else begin
                  hold_n = hold_cnt + HW'(1);
               end
            end
         end

         S_WAIT: begin
            if (tx_done) begin
               if (last_q || burst_cnt == BW'(MAX_BURST)) begin
                  rel = 1'b1;
               end else begin
                  state_n = S_SEND;
               end
            end
         end

         default: state_n = S_IDLE;
      endcase

      if (rel) begin
         state_n = S_IDLE;
         rr_n    = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + IDW'(1);
         burst_n = '0;
         hold_n  = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         rr_ptr    <= '0;
         grant_id  <= '0;
         burst_cnt <= '0;
         hold_cnt  <= '0;
         last_q    <= 1'b0;
         tx_start  <= 1'b0;
         tx_data   <= '0;
      end else begin
         state     <= state_n;
         rr_ptr    <= rr_n;
         grant_id  <= gid_n;
         burst_cnt <= burst_n;
         hold_cnt  <= hold_n;
         last_q    <= last_n;
         tx_start  <= start_n;
         tx_data   <= data_n;
      end
   end

   assign grant_active = (state != S_IDLE);
   assign state_dbg    = state;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: requester queues, a uart_tx stand-in, and a packet-level
// round-robin model that predicts the (grantee, byte) stream seen on tx_start.
module tb_uart_tx_scheduler;

   localparam int N   = 4;
   localparam int DW  = 8;
   localparam int MB  = 16;
   localparam int HT  = 64;
   localparam int IDW = 2;
   localparam int EW  = IDW + DW;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic [N-1:0]    req_valid = '0;
   logic [N*DW-1:0] req_data = '0;
   logic [N-1:0]    req_last = '0;
   logic [N-1:0]    req_ready;
   logic            tx_start;
   logic [DW-1:0]   tx_data;
   logic            tx_busy;
   logic            tx_done;
   logic            grant_active;
   logic [IDW-1:0]  grant_id;
   logic [1:0]      state_dbg;

   logic [EW-1:0]   exp_q[$];
   logic [DW:0]     rq_mem [N][256];
   int              rq_head [N];
   int              rq_tail [N];

   int              errors = 0;
   int              checks = 0;
   int              frame_len = 4;
   int              ucnt = 0;
   logic            ubusy = 1'b0;
   logic            udone = 1'b0;
   logic            force_busy = 1'b0;
   logic            force_done = 1'b0;
   logic [N-1:0]    hs_edge;
   int              cyc = 0;
   int              last_done_cyc = -100;
   logic [IDW-1:0]  last_start_gid = '0;
   int              done_count = 0;
   int              start_count = 0;
   int              model_rr = 0;

   assign tx_busy = ubusy | force_busy;
   assign tx_done = udone | force_done;

   uart_tx_scheduler #(
      .NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB), .HOLD_TIMEOUT(HT)
   ) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
      .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .tx_done(tx_done),
      .grant_active(grant_active), .grant_id(grant_id), .state_dbg(state_dbg)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #900000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   always @(posedge clk or posedge reset) begin
      if (reset) hs_edge <= '0;
      else       hs_edge <= req_valid & req_ready;
   end

   // ---------------- requester drivers, uart_tx stand-in, tx_start scoreboard ----------------
   initial begin
      logic [EW-1:0] e;
      int need;
      forever begin
         @(negedge clk);
         cyc++;
         if (!reset) begin
            for (int i = 0; i < N; i++) if (hs_edge[i]) rq_head[i]++;
         end
         if (tx_start === 1'b1) begin
            start_count++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_start got id=%0d data=%02h expected none", grant_id, tx_data);
            end else begin
               e = exp_q.pop_front();
               if ({grant_id, tx_data} !== e)
                  begin errors++; $display("FAIL start_byte got id=%0d data=%02h expected id=%0d data=%02h",
                                            grant_id, tx_data, e[EW-1:DW], e[DW-1:0]); end
            end
            checks++;
            if (hs_edge === '0) begin
               errors++; $display("FAIL start_latency tx_start without handshake on previous edge");
            end
            need = (grant_id == last_start_gid) ? 2 : 3;
            checks++;
            if (cyc - last_done_cyc < need) begin
               errors++; $display("FAIL start_gap got=%0d cycles required>=%0d", cyc - last_done_cyc, need);
            end
            last_start_gid = grant_id;
         end
         if (reset) begin
            ubusy = 1'b0; udone = 1'b0; ucnt = 0;
         end else begin
            udone = 1'b0;
            if (tx_start === 1'b1) begin
               ubusy = 1'b1; ucnt = frame_len;
            end else if (ubusy) begin
               ucnt--;
               if (ucnt == 0) begin
                  ubusy = 1'b0; udone = 1'b1; done_count++; last_done_cyc = cyc;
               end
            end
         end
         for (int i = 0; i < N; i++) begin
            if (rq_head[i] < rq_tail[i]) begin
               req_valid[i]          = 1'b1;
               req_data[i*DW +: DW]  = rq_mem[i][rq_head[i] & 255][DW-1:0];
               req_last[i]           = rq_mem[i][rq_head[i] & 255][DW];
            end else begin
               req_valid[i]          = 1'b0;
               req_data[i*DW +: DW]  = '0;
               req_last[i]           = 1'b0;
            end
         end
         #1;
         checks++;
         if ($countones(req_ready) > 1 || (req_ready != '0 && !grant_active)) begin
            errors++; $display("FAIL ready_exclusive got=%b grant_active=%0b", req_ready, grant_active);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(negedge clk);
      #2;
   endtask

   task automatic push(input int r, input logic [DW-1:0] d, input logic l);
      rq_mem[r][rq_tail[r] & 255] = {l, d};
      rq_tail[r]++;
   endtask

   function automatic bit pending();
      for (int i = 0; i < N; i++) if (rq_head[i] < rq_tail[i]) return 1'b1;
      return 1'b0;
   endfunction

   // Packet-level round robin: grantee sends until last, MAX_BURST bytes, or its queue runs dry.
   task automatic build_expected();
      int h [N];
      int rr, g, n, c;
      bit stop;
      logic [DW:0] b;
      for (int i = 0; i < N; i++) h[i] = rq_head[i];
      rr = model_rr;
      while (1) begin
         g = -1;
         for (int k = 0; k < N; k++) begin
            c = (rr + k) % N;
            if (g < 0 && h[c] < rq_tail[c]) g = c;
         end
         if (g < 0) break;
         n = 0;
         stop = 1'b0;
         while (!stop) begin
            b = rq_mem[g][h[g] & 255];
            h[g]++;
            n++;
            exp_q.push_back({IDW'(g), b[DW-1:0]});
            stop = b[DW] || n == MB || h[g] == rq_tail[g];
         end
         rr = (g + 1) % N;
      end
      model_rr = rr;
   endtask

   task automatic wait_drain(input string name, input int budget);
      int n = 0;
      while ((exp_q.size() != 0 || grant_active || pending()) && n < budget) begin
         step();
         n++;
      end
      checks++;
      if (n >= budget) begin
         errors++;
         $display("FAIL %s_drain bytes_left=%0d grant_active=%0b expected drained", name, exp_q.size(), grant_active);
      end
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      force_busy = 1'b0;
      force_done = 1'b0;
      for (int i = 0; i < N; i++) begin rq_head[i] = 0; rq_tail[i] = 0; end
      exp_q.delete();
      model_rr = 0;
      last_done_cyc = -100;
      repeat (2) step();
      @(negedge clk);
      reset = 1'b0;
      #2;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset = 1'b1;
      step();
      checks++; if (grant_active !== 1'b0) begin errors++; $display("FAIL reset_grant_active got=%b expected 0", grant_active); end
      checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_req_ready got=%b expected 0", req_ready); end
      checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start got=%b expected 0", tx_start); end
      checks++; if (tx_data !== '0) begin errors++; $display("FAIL reset_tx_data got=%h expected 0", tx_data); end
      checks++; if (grant_id !== '0) begin errors++; $display("FAIL reset_grant_id got=%0d expected 0", grant_id); end
      apply_reset();
   endtask

   task automatic test_single_packet();
      int s0;
      frame_len = 5;
      s0 = start_count;
      push(1, 8'hA5, 1'b0); push(1, 8'h3C, 1'b0); push(1, 8'h7E, 1'b1);
      build_expected();
      wait_drain("single", 2000);
      checks++; if (start_count - s0 != 3) begin errors++; $display("FAIL single_starts got=%0d expected 3", start_count - s0); end
      checks++; if (grant_active !== 1'b0) begin errors++; $display("FAIL single_release got=%b expected 0", grant_active); end
      checks++; if (grant_id !== 2'd1) begin errors++; $display("FAIL single_grant_id got=%0d expected 1", grant_id); end
      // rr_ptr should now be 2: with 0,1,2 all waiting, 2 goes first.
      push(0, 8'h01, 1'b1); push(1, 8'h02, 1'b1); push(2, 8'h03, 1'b1);
      build_expected();
      wait_drain("after_single", 2000);
   endtask

   task automatic test_all_four();
      apply_reset();
      frame_len = 3;
      for (int i = 0; i < N; i++) push(i, DW'(8'h10 + i), 1'b1);
      build_expected();
      wait_drain("all_four", 2000);
      checks++; if (grant_id !== 2'd3) begin errors++; $display("FAIL all_four_last_grant got=%0d expected 3", grant_id); end
   endtask

   task automatic test_burst_limit();
      apply_reset();
      frame_len = 2;
      for (int b = 0; b < 20; b++) push(2, DW'($urandom_range(0, 255)), 1'b0);
      push(3, 8'hC0, 1'b0); push(3, 8'hC1, 1'b1);
      build_expected();
      wait_drain("burst", 4000);
      checks++; if (grant_id !== 2'd2) begin errors++; $display("FAIL burst_last_grant got=%0d expected 2", grant_id); end
   endtask

   task automatic test_hold_timeout();
      int d0, s0, n, cnt;
      apply_reset();
      frame_len = 4;
      push(0, 8'h5A, 1'b0);
      build_expected();
      d0 = done_count;
      n = 0;
      while (done_count == d0 && n < 200) begin step(); n++; end
      checks++; if (n >= 200) begin errors++; $display("FAIL hold_wait_done no tx_done seen expected one"); end
      cnt = 0;
      n = 0;
      while (n < 300) begin
         step();
         n++;
         if (grant_active) cnt++;
         else break;
      end
      checks++; if (cnt != HT) begin errors++; $display("FAIL hold_send_cycles got=%0d expected %0d", cnt, HT); end
      s0 = start_count;
      repeat (20) step();
      checks++; if (start_count != s0) begin errors++; $display("FAIL hold_no_restart got=%0d extra starts expected 0", start_count - s0); end
      checks++; if (grant_active !== 1'b0) begin errors++; $display("FAIL hold_idle got=%b expected 0", grant_active); end
      wait_drain("hold", 100);
   endtask

   task automatic test_reset_mid_frame();
      int s0, n;
      apply_reset();
      frame_len = 20;
      push(1, DW'($urandom_range(1, 255)) | 8'h01, 1'b0);
      build_expected();
      s0 = start_count;
      n = 0;
      while (start_count == s0 && n < 50) begin step(); n++; end
      repeat (5) step();
      checks++; if (grant_active !== 1'b1) begin errors++; $display("FAIL midreset_pre_grant got=%b expected 1", grant_active); end
      reset = 1'b1;
      #1;
      checks++; if (grant_active !== 1'b0) begin errors++; $display("FAIL midreset_grant_active got=%b expected 0", grant_active); end
      checks++; if (tx_data !== '0) begin errors++; $display("FAIL midreset_tx_data got=%h expected 0", tx_data); end
      checks++; if (grant_id !== '0) begin errors++; $display("FAIL midreset_grant_id got=%0d expected 0", grant_id); end
      checks++; if (req_ready !== '0 || tx_start !== 1'b0) begin errors++; $display("FAIL midreset_ready_start got=%b/%b expected 0", req_ready, tx_start); end
      repeat (2) step();
      exp_q.delete();
      model_rr = 0;
      last_done_cyc = -100;
      frame_len = 3;
      push(3, 8'h77, 1'b1);
      build_expected();
      @(negedge clk);
      reset = 1'b0;
      #2;
      wait_drain("midreset", 500);
      checks++; if (grant_id !== 2'd3) begin errors++; $display("FAIL midreset_regrant got=%0d expected 3", grant_id); end
   endtask

   task automatic test_busy_block();
      int n;
      apply_reset();
      frame_len = 3;
      force_busy = 1'b1;
      push(1, 8'h99, 1'b1);
      build_expected();
      n = 0;
      while (!grant_active && n < 20) begin step(); n++; end
      checks++; if (!grant_active) begin errors++; $display("FAIL busy_grant got=%b expected 1", grant_active); end
      for (int c = 0; c < 5; c++) begin
         step();
         checks++; if (req_ready !== '0) begin errors++; $display("FAIL busy_ready_blocked got=%b expected 0", req_ready); end
      end
      force_done = 1'b1;
      step();
      force_done = 1'b0;
      checks++; if (state_dbg !== 2'd1 || grant_id !== 2'd1) begin errors++; $display("FAIL busy_spurious_done state=%0d id=%0d expected SEND id 1", state_dbg, grant_id); end
      force_busy = 1'b0;
      #1;
      checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL busy_ready_release got=%b expected 0010", req_ready); end
      step();
      checks++; if (tx_start !== 1'b1 || tx_data !== 8'h99) begin errors++; $display("FAIL busy_start got=%b/%h expected 1/99", tx_start, tx_data); end
      wait_drain("busy", 200);
   endtask

   task automatic test_random();
      int np, r, len;
      bit nolast;
      for (int round = 0; round < 4; round++) begin
         frame_len = $urandom_range(1, 5);
         np = $urandom_range(2, 7);
         for (int p = 0; p < np; p++) begin
            r = $urandom_range(0, N - 1);
            len = $urandom_range(1, 10);
            nolast = ($urandom_range(0, 4) == 0);
            for (int b = 0; b < len; b++)
               push(r, DW'($urandom_range(0, 255)), (b == len - 1) && !nolast);
         end
         build_expected();
         wait_drain("random", 20000);
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_single_packet();
      test_all_four();
      test_burst_limit();
      test_hold_timeout();
      test_reset_mid_frame();
      test_busy_block();
      test_random();
      repeat (3) step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
